// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two issuing units, the shared-ALU arbiter and the result consumer.
interface alu_arbiter_if;
  logic        req0_valid;
  logic [2:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [2:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters; operands are held
// in registers for EXEC_CYCLES so a slow ALU settles before the result is captured.
module alu_arbiter #(
  parameter int EXEC_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e           state_q;
  logic             last_q;
  logic             id_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_valid_q, rsp_id_q, rsp_ovf_q;
  logic [31:0]      rsp_result_q;

  logic        any_vld, gnt_id;
  logic [31:0] sum, diff, alu_y;
  logic        alu_ovf;

  // On a tie the requester not served last wins.
  assign any_vld = bus.req0_valid | bus.req1_valid;
  assign gnt_id  = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;

  assign bus.req0_ready   = (state_q == IDLE) & bus.req0_valid & ~gnt_id;
  assign bus.req1_ready   = (state_q == IDLE) & bus.req1_valid &  gnt_id;
  assign bus.busy         = (state_q != IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_ovf_q;

  // Shared ALU, fed only from the registered operands; overflow exists only for ADD/SUB.
  always_comb begin
    sum     = a_q + b_q;
    diff    = a_q - b_q;
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (op_q)
      3'd0: begin alu_y = sum;  alu_ovf = (a_q[31] == b_q[31]) & (sum[31]  != a_q[31]); end
      3'd1: begin alu_y = diff; alu_ovf = (a_q[31] != b_q[31]) & (diff[31] != a_q[31]); end
      3'd2: alu_y = a_q ^ b_q;
      3'd3: alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
      3'd4: alu_y = a_q & b_q;
      3'd5: alu_y = ~(a_q & b_q);
      3'd6: alu_y = ~(a_q | b_q);
      default: alu_y = a_q | b_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_vld) begin
          id_q    <= gnt_id;
          last_q  <= gnt_id;
          op_q    <= gnt_id ? bus.req1_op : bus.req0_op;
          a_q     <= gnt_id ? bus.req1_a  : bus.req0_a;
          b_q     <= gnt_id ? bus.req1_b  : bus.req0_b;
          cnt_q   <= CNT_W'(EXEC_CYCLES - 1);
          state_q <= EXEC;
        end
        EXEC: if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          rsp_result_q <= alu_y;
          rsp_ovf_q    <= alu_ovf;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int EXEC_A = 4;
  localparam int EXEC_B = 1;

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { logic id; logic [31:0] res; logic ovf; } rsp_t;

  logic clk = 1'b0, reset = 1'b1, rst_b = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if ifa();
  alu_arbiter_if ifb();

  alu_arbiter #(.EXEC_CYCLES(EXEC_A), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  alu_arbiter #(.EXEC_CYCLES(EXEC_B), .CNT_W(8)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

  int n_chk = 0, n_fail = 0;
  int ecnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Reference ALU from signed integer arithmetic: returns {overflow, result}.
  function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, s;
    logic [31:0] r;
    logic o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    o = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd1: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      3'd2: r = a ^ b;
      3'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {o, r};
  endfunction

  // ---------------- requester drivers (queue-based, hold until ready) ----------------
  op_t q0[$], q1[$];
  bit took0, took1;

  always @(negedge clk) begin
    took0 = ifa.req0_ready;
    took1 = ifa.req1_ready;
  end

  initial begin
    ifa.req0_valid = 0; ifa.req0_op = 0; ifa.req0_a = 0; ifa.req0_b = 0;
    ifa.req1_valid = 0; ifa.req1_op = 0; ifa.req1_a = 0; ifa.req1_b = 0;
    forever begin
      @(posedge clk); #1;
      if (took0 && q0.size() > 0) q0.delete(0);
      if (took1 && q1.size() > 0) q1.delete(0);
      took0 = 0; took1 = 0;
      ifa.req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin ifa.req0_op = q0[0].op; ifa.req0_a = q0[0].a; ifa.req0_b = q0[0].b; end
      ifa.req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin ifa.req1_op = q1[0].op; ifa.req1_a = q1[0].a; ifa.req1_b = q1[0].b; end
    end
  end

  // ---------------- reference model: one transaction in flight, timed by edge numbers ----------------
  bit          m_init = 0, m_busy = 0, m_last = 1;
  int          m_acc_e = 0;
  logic        p_id, h_id;
  logic [31:0] p_res, h_res;
  logic        p_ovf, h_ovf;

  function automatic logic winner(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1;
  endfunction

  always @(posedge clk) begin
    logic w;
    logic [32:0] r;
    ecnt++;
    if (reset) begin
      m_init = 1; m_busy = 0; m_last = 1;
      h_id = 0; h_res = 0; h_ovf = 0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (ifa.req0_valid || ifa.req1_valid) begin
          w = winner(ifa.req0_valid, ifa.req1_valid, m_last);
          r = w ? alu_ref(ifa.req1_op, ifa.req1_a, ifa.req1_b) : alu_ref(ifa.req0_op, ifa.req0_a, ifa.req0_b);
          p_id = w; p_res = r[31:0]; p_ovf = r[32];
          m_last = w; m_busy = 1; m_acc_e = ecnt;
        end
      end else if ((ecnt - 1 >= m_acc_e + EXEC_A) && ifa.rsp_ready) begin
        h_id = p_id; h_res = p_res; h_ovf = p_ovf;
        m_busy = 0;
      end
    end
  end

  // Single compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    logic rv, w;
    if (m_init) begin
      rv = m_busy && (ecnt >= m_acc_e + EXEC_A);
      w  = winner(ifa.req0_valid, ifa.req1_valid, m_last);
      chk("req0_ready", ifa.req0_ready, !m_busy && ifa.req0_valid && !w);
      chk("req1_ready", ifa.req1_ready, !m_busy && ifa.req1_valid &&  w);
      chk("busy",       ifa.busy, m_busy);
      chk("rsp_valid",  ifa.rsp_valid, rv);
      chk("rsp_result", ifa.rsp_result, rv ? p_res : h_res);
      chk("rsp_id",     ifa.rsp_id, rv ? p_id : h_id);
      chk("rsp_ovf",    ifa.rsp_overflow, rv ? p_ovf : h_ovf);
    end
  end

  // Response log of completed handshakes on the EXEC_CYCLES=4 instance.
  rsp_t alog[$];
  always @(negedge clk)
    if (!reset && ifa.rsp_valid && ifa.rsp_ready)
      alog.push_back('{id: ifa.rsp_id, res: ifa.rsp_result, ovf: ifa.rsp_overflow});

  // ---------------- EXEC_CYCLES=1 instance: both requesters always valid ----------------
  logic        bid[6];
  logic [31:0] bres[6];
  int          be[6];
  int          bcnt = 0;

  initial begin
    ifb.req0_valid = 1; ifb.req0_op = 3'd0; ifb.req0_a = 32'd3; ifb.req0_b = 32'd4;
    ifb.req1_valid = 1; ifb.req1_op = 3'd1; ifb.req1_a = 32'd3; ifb.req1_b = 32'd4;
    ifb.rsp_ready  = 1;
    repeat (2) @(posedge clk);
    #1 rst_b = 0;
  end

  always @(negedge clk)
    if (!rst_b && ifb.rsp_valid && bcnt < 6) begin
      bid[bcnt] = ifb.rsp_id; bres[bcnt] = ifb.rsp_result; be[bcnt] = ecnt;
      bcnt++;
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random script ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (alog.size() < n && k < 300) begin cyc(1); k++; end
    chk("log_wait", alog.size() >= n, 1);
  endtask

  function automatic op_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] sp [5];
    sp[0] = 32'h0; sp[1] = 32'h1; sp[2] = 32'h7FFFFFFF; sp[3] = 32'h80000000; sp[4] = 32'hFFFFFFFF;
    if ($urandom % 4 == 0) return sp[$urandom % 5];
    return $urandom;
  endfunction

  initial begin
    int k, acc_e;
    ifa.rsp_ready = 1;
    reset = 1;
    cyc(2);
    reset = 0;
    @(negedge clk);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_rsp_valid", ifa.rsp_valid, 0);
    chk("rst_rsp_result", ifa.rsp_result, 0);
    chk("rst_rsp_id", ifa.rsp_id, 0);
    chk("rst_rsp_ovf", ifa.rsp_overflow, 0);
    cyc(1);

    // 1: single ADD, latency from accept edge
    q0.push_back(mk(3'd0, 32'd2, 32'd1));
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.req0_ready && k < 20);
    chk("t1_ready0", ifa.req0_ready, 1);
    acc_e = ecnt + 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.rsp_valid && k < 20);
    chk("t1_latency", ecnt - acc_e, EXEC_A);
    chk("t1_result", ifa.rsp_result, 32'd3);
    chk("t1_id", ifa.rsp_id, 0);
    chk("t1_ovf", ifa.rsp_overflow, 0);
    cyc(2);

    // 2: tie straight after reset, then a second tie
    reset = 1; cyc(1); reset = 0;
    alog.delete();
    q0.push_back(mk(3'd1, 32'd10, 32'd13));
    q1.push_back(mk(3'd6, 32'd2, 32'd1));
    wait_log(2);
    chk("t2_first_id", alog[0].id, 0);
    chk("t2_first_res", alog[0].res, 32'hFFFFFFFD);
    chk("t2_first_ovf", alog[0].ovf, 0);
    chk("t2_second_id", alog[1].id, 1);
    chk("t2_second_res", alog[1].res, 32'hFFFFFFFC);
    q0.push_back(mk(3'd2, 32'hF0, 32'h0F));
    q1.push_back(mk(3'd7, 32'h1, 32'h2));
    wait_log(4);
    chk("t2_third_id", alog[2].id, 0);
    chk("t2_third_res", alog[2].res, 32'hFF);
    chk("t2_fourth_id", alog[3].id, 1);

    // 3: signed overflow boundary, SLT masks overflow
    alog.delete();
    q0.push_back(mk(3'd0, 32'h7FFFFFFF, 32'd1));
    wait_log(1);
    chk("t3_add_res", alog[0].res, 32'h80000000);
    chk("t3_add_ovf", alog[0].ovf, 1);
    q0.push_back(mk(3'd3, 32'h80000000, 32'd1));
    wait_log(2);
    chk("t3_slt_res", alog[1].res, 32'd1);
    chk("t3_slt_ovf", alog[1].ovf, 0);
    cyc(2);

    // 4: consumer stalls for 10 cycles with both requesters waiting (last = 0, so req1 wins)
    ifa.rsp_ready = 0;
    alog.delete();
    q0.push_back(mk(3'd2, 32'd5, 32'd3));
    q1.push_back(mk(3'd4, 32'hF0, 32'h3C));
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.rsp_valid && k < 30);
    chk("t4_rsp_seen", ifa.rsp_valid, 1);
    repeat (10) begin
      @(negedge clk);
      chk("t4_hold_valid", ifa.rsp_valid, 1);
      chk("t4_hold_res", ifa.rsp_result, 32'h30);
      chk("t4_hold_id", ifa.rsp_id, 1);
      chk("t4_hold_rdy", {ifa.req0_ready, ifa.req1_ready}, 0);
      chk("t4_hold_busy", ifa.busy, 1);
    end
    @(posedge clk); #2;
    ifa.rsp_ready = 1;
    wait_log(2);
    chk("t4_second_id", alog[1].id, 0);
    chk("t4_second_res", alog[1].res, 32'd6);
    cyc(2);

    // 5: reset in the 2nd EXEC cycle drops the op (last = 0 so req1's OR 1,2 is the victim)
    alog.delete();
    q0.push_back(mk(3'd0, 32'd1, 32'd1));
    q0.push_back(mk(3'd0, 32'd2, 32'd2));
    q1.push_back(mk(3'd7, 32'd1, 32'd2));
    q1.push_back(mk(3'd7, 32'd4, 32'd8));
    k = 0;
    do begin @(negedge clk); k++; end while (!ifa.req1_ready && k < 20);
    chk("t5_ready1", ifa.req1_ready, 1);
    @(posedge clk);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("t5_rsp_valid", ifa.rsp_valid, 0);
    chk("t5_busy", ifa.busy, 0);
    chk("t5_tie_ready0", ifa.req0_ready, 1);
    chk("t5_tie_ready1", ifa.req1_ready, 0);
    wait_log(3);
    cyc(30);
    chk("t5_count", alog.size(), 3);
    chk("t5_r0", alog[0].res, 32'd2);
    chk("t5_r1", alog[1].res, 32'd12);
    chk("t5_r2", alog[2].res, 32'd4);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      if (q0.size() < 3 && $urandom % 3 == 0) q0.push_back(mk(3'($urandom % 8), rnd_opnd(), rnd_opnd()));
      if (q1.size() < 3 && $urandom % 3 == 0) q1.push_back(mk(3'($urandom % 8), rnd_opnd(), rnd_opnd()));
      ifa.rsp_ready = ($urandom % 4) != 0;
      cyc(1);
    end
    ifa.rsp_ready = 1;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && k < 500) begin cyc(1); k++; end
    chk("drain", (q0.size() == 0) && (q1.size() == 0) && !m_busy, 1);

    // 6: EXEC_CYCLES=1 instance alternates ids, one response every 3 cycles
    chk("t6_count", bcnt, 6);
    for (int i = 0; i < 6 && i < bcnt; i++) begin
      chk("t6_id", bid[i], i % 2);
      chk("t6_res", bres[i], (i % 2) ? 32'hFFFFFFFF : 32'd7);
      if (i > 0) chk("t6_period", be[i] - be[i-1], 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
